// File: rtl/firing_pkg.sv
// Shared encodings for the firing controller: control words, FSM states, magazine size.
package firing_pkg;

  localparam logic [2:0] CTRL_RELOAD = 3'b000;
  localparam logic [2:0] CTRL_HOLD   = 3'b001;
  localparam logic [2:0] CTRL_SHOT   = 3'b011;

  localparam logic [1:0] MAX_SHOTS_DEFAULT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FIRE      = 3'd1,
    S_COOLDOWN  = 3'd2,
    S_WAIT_REL  = 3'd3,
    S_RELOADING = 3'd4
  } state_t;

endpackage

// File: rtl/firing_control_debounce.sv
// Button conditioning: 2-flop synchronizer, stability-counter debouncer, rising-edge press pulse.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 16'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;
  logic          level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= 2'b00;
      cnt     <= '0;
      level_q <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level_q;
      // Any cycle agreeing with the current level restarts the stability count.
      if (sync[1] == level_q) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 16'd1)) begin
        level_q <= sync[1];
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_d;

endmodule

// File: rtl/firing_control.sv
// Firing controller: debounced trigger/reload buttons to HOLD/SHOT/RELOAD control word with cooldown and timed reload.
// Define FIRING_AUTO_RELOAD_EN to start a reload automatically when the magazine is empty.
module firing_control
  import firing_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd2500000,
  parameter logic [23:0] RELOAD_CYCLES   = 24'd5000000,
  parameter logic [1:0]  MAX_SHOTS       = MAX_SHOTS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger_btn,
  input  logic       reload_btn,
  input  logic [1:0] RemainingShots,
  input  logic       isShot,
  output logic [2:0] control,
  output logic       shot_fired,
  output logic       dry_fire,
  output logic       busy
);

  localparam int CD_W  = (COOLDOWN_CYCLES > 24'd1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int RL_W  = (RELOAD_CYCLES > 24'd1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam int CNT_W = (CD_W > RL_W) ? CD_W : RL_W;

  logic trig_level, trig_press;
  logic reload_level_unused, reload_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig_db (
    .clk(clk), .reset(reset), .btn(trigger_btn), .level(trig_level), .press(trig_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reload_db (
    .clk(clk), .reset(reset), .btn(reload_btn), .level(reload_level_unused), .press(reload_press)
  );

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       control_next;
  logic             dry_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      control    <= CTRL_HOLD;
      shot_fired <= 1'b0;
      dry_fire   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      control    <= control_next;
      shot_fired <= (state_next == S_FIRE);
      dry_fire   <= dry_next;
      busy       <= (state_next == S_COOLDOWN) || (state_next == S_RELOADING);
    end
  end

  always_comb begin
    state_next   = state;
    dry_next     = 1'b0;
    control_next = CTRL_HOLD;
    case (state)
      S_IDLE: begin
        // A registered hit ends the round: no trigger or reload is honoured until reset.
        if (!isShot) begin
          if (trig_press) begin
            if (RemainingShots != 2'd0) state_next = S_FIRE;
            else                        dry_next   = 1'b1;
          end else if (reload_press && (RemainingShots < MAX_SHOTS)) begin
            state_next = S_RELOADING;
          end
`ifdef FIRING_AUTO_RELOAD_EN
          else if (RemainingShots == 2'd0) begin
            state_next = S_RELOADING;
          end
`endif
        end
      end
      S_FIRE:      state_next = S_COOLDOWN;
      S_COOLDOWN:  if (cnt == CNT_W'(COOLDOWN_CYCLES - 24'd1)) state_next = S_WAIT_REL;
      S_WAIT_REL:  if (!trig_level) state_next = S_IDLE;
      S_RELOADING: if (cnt == CNT_W'(RELOAD_CYCLES - 24'd1)) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    case (state_next)
      S_FIRE:      control_next = CTRL_SHOT;
      S_RELOADING: control_next = CTRL_RELOAD;
      default:     control_next = CTRL_HOLD;
    endcase
  end

endmodule

// File: doc/firing_control.md
Name: firing_control

Overview:
- Controller end of the firing interface.
- Turns raw trigger and reload buttons into the 3-bit control word consumed by the firing datapath: reload, hold, or single-cycle shot.
- Reads the datapath's remaining-shot count and hit flag as feedback; enforces one shot per press, a post-shot cooldown, and timed reloads.
- Sits between the board pushbuttons and the firing datapath, in the same clk domain.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: cycles an input must be stable before a level change is accepted.
- COOLDOWN_CYCLES, 24'd2500000: minimum cycles from a shot to the next accepted trigger.
- RELOAD_CYCLES, 24'd5000000: cycles the control word is held at reload.
- MAX_SHOTS, 2'd3: magazine size; a value below this enables a reload.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- trigger_btn  input  1  raw trigger button, asynchronous, active-high
- reload_btn  input  1  raw reload button, asynchronous, active-high
- RemainingShots  input  2  shots left, from datapath
- isShot  input  1  bird-hit flag, from datapath
- control  output  3  command word to datapath
- shot_fired  output  1  one-cycle pulse when a shot is issued
- dry_fire  output  1  one-cycle pulse on a trigger press with RemainingShots==0
- busy  output  1  high in S_COOLDOWN or S_RELOADING

Behaviour:
- Reset: async on posedge reset. Values during reset:
  - control=3'b001 (hold); shot_fired=0; dry_fire=0; busy=0.
  - FSM=S_IDLE; all counters 0; synchronizers and debounced levels 0.
- Control encodings: RELOAD=3'b000, HOLD=3'b001, SHOT=3'b011. No other value is ever driven.
- Input conditioning: each button passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer updates its level only after DEBOUNCE_CYCLES consecutive cycles of the opposite synchronized value.
  - Rising-edge detect on the debounced level gives trig_press / reload_press, each one cycle.
  - Latency from raw press to press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM, all outputs registered:
  - S_IDLE: control=HOLD.
    - trig_press && !isShot && RemainingShots!=0 -> S_FIRE.
    - trig_press && RemainingShots==0 -> dry_fire pulse next cycle; stay in S_IDLE.
    - reload_press && RemainingShots<MAX_SHOTS && !isShot -> S_RELOADING.
    - Trigger takes priority over reload when both press pulses occur in the same cycle.
  - S_FIRE: control=SHOT for exactly one cycle; shot_fired=1 in the same cycle -> S_COOLDOWN.
  - S_COOLDOWN: control=HOLD; busy=1; counter counts 0..COOLDOWN_CYCLES-1 -> S_WAIT_REL. Presses are ignored.
  - S_WAIT_REL: control=HOLD; waits until the debounced trigger level is 0 -> S_IDLE. Holding the trigger never auto-fires.
  - S_RELOADING: control=RELOAD; busy=1; counter counts to RELOAD_CYCLES-1 -> S_IDLE. Trigger presses are ignored, not queued.
- isShot high: trigger and reload are ignored in S_IDLE (round over). Only reset clears this condition.
- Counters: saturate-free, cleared on every state entry; width is $clog2 of the parameter.
- Reset mid-operation: a SHOT or RELOAD in progress is abandoned and control returns to HOLD immediately (asynchronously).
- RemainingShots changing during S_COOLDOWN has no effect until S_IDLE.

Optional Feature:
- Macro: FIRING_AUTO_RELOAD_EN.
- Defined: in S_IDLE, RemainingShots==0 && !isShot enters S_RELOADING automatically on the next cycle, without a reload press.
- Undefined: reload happens only on reload_press.

Decomposition:
- Shared package/header firing_pkg:
  - control encodings CTRL_RELOAD, CTRL_HOLD, CTRL_SHOT.
  - FSM state encoding, 3 bits: S_IDLE, S_FIRE, S_COOLDOWN, S_WAIT_REL, S_RELOADING.
  - MAX_SHOTS default.
- Sub-module: button_debounce.
  - Contains the synchronizer, stability counter and rising-edge pulse; parameter DEBOUNCE_CYCLES.
  - Instantiated twice, once per button.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, RELOAD_CYCLES=10 for all scenarios):
- Trigger press with RemainingShots=3, isShot=0 -> exactly one cycle of control=3'b011 with shot_fired=1, 7 cycles after the press; then busy=1 for 8 cycles.
- Trigger held for 100 cycles -> exactly one SHOT cycle; a second SHOT only after release, then a new press.
- A 2-cycle glitch pulse on trigger_btn -> no SHOT, control stays 3'b001.
- RemainingShots=0, trigger press -> one dry_fire pulse, no SHOT. With FIRING_AUTO_RELOAD_EN defined, the bench drives RemainingShots=0 with no press -> control=3'b000 for 10 cycles, then 3'b001.
- reload_press with RemainingShots=1 -> control=3'b000 for 10 cycles. A trigger press during that window is ignored. reload_press with RemainingShots=3 -> no reload.
- Reset asserted during S_RELOADING cycle 5 -> control=3'b001 and busy=0 without waiting for clk. isShot=1, then trigger press -> no SHOT.
